stage_ma: RTL and testbench

STAGE_MA -- requirements
Module: stage_ma

---
 rtl/stage_ma_pkg.sv | 28 ++
 rtl/ma_lane_align.sv | 64 ++++++
 rtl/stage_ma.sv | 189 ++++++++++++++++++
 tb/tb_stage_ma.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_ma_pkg.sv
// Shared definitions for the memory-access stage: WB/MA control field indices,
// access size encodings and FSM state encodings.
package stage_ma_pkg;

  // WB control field indices
  localparam int unsigned WB_R_WE        = 2;
  localparam int unsigned WB_RDST_MUX_HI = 1;
  localparam int unsigned WB_RDST_MUX_LO = 0;

  // MA control field indices
  localparam int unsigned MA_RD      = 0;
  localparam int unsigned MA_WR      = 1;
  localparam int unsigned MA_SIZE_LO = 2;
  localparam int unsigned MA_SIZE_HI = 3;
  localparam int unsigned MA_UNS     = 4;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10
  } ma_size_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } ma_state_e;

endpackage

// File: rtl/ma_lane_align.sv
// Byte-lane steering for the MA stage: store byte enables and replication, load extract/extend.
// Sub-word support is compiled in only when MA_SUBWORD_EN is defined.
module ma_lane_align
  import stage_ma_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misalign,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

`ifdef MA_SUBWORD_EN
  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'hF;
    st_wdata = st_data;
    misalign = 1'b0;
    case (st_size)
      SzByte: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SzHalf: begin
        st_be    = 4'b0011 << st_addr_lo;
        st_wdata = {2{st_data[15:0]}};
        misalign = st_addr_lo[0];
      end
      default: misalign = |st_addr_lo;
    endcase
  end

  assign ld_shifted = rdata >> {ld_addr_lo, 3'b000};
  assign ld_byte    = ld_shifted[7:0];
  assign ld_half    = ld_shifted[15:0];

  always_comb begin
    ld_data = rdata;
    case (ld_size)
      SzByte:  ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SzHalf:  ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end
`else
  logic unused_lane;

  assign unused_lane = ^{st_addr_lo, st_size, ld_addr_lo, ld_size, ld_unsigned};
  assign st_be       = 4'hF;
  assign st_wdata    = st_data;
  assign misalign    = 1'b0;
  assign ld_data     = rdata;
`endif

endmodule

// File: rtl/stage_ma.sv
// Memory-access pipeline stage: IDLE/ACCESS handshake with data memory and the MA/WB register.
// Define MA_SUBWORD_EN for byte/half accesses; otherwise every access is an aligned word.
module stage_ma
  import stage_ma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ma_valid,
  input  logic [31:0] i_ma_pc,
  input  logic [31:0] i_ma_alu_rslt,
  input  logic [31:0] i_ma_st_data,
  input  logic [4:0]  i_ma_mem_cntrl,
  input  logic [2:0]  i_ma_wb_cntrl,
  input  logic [4:0]  i_ma_rdst,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  output logic [3:0]  o_dm_be,
  input  logic        i_dm_ack,
  input  logic [31:0] i_dm_rdata,
  output logic        o_ma_stall,
  output logic        o_ma_misalign,
  output logic        o_ma_valid,
  output logic [31:0] o_ma_pc,
  output logic [31:0] o_ma_data_o,
  output logic [31:0] o_ma_alu_rslt,
  output logic [2:0]  o_ma_cntrl,
  output logic [4:0]  o_ma_rdst
);

  ma_state_e   state_q, state_d;

  logic        acc_we_q, acc_uns_q;
  logic [1:0]  acc_size_q;
  logic [31:0] acc_addr_q, acc_wdata_q, acc_pc_q, acc_alu_q;
  logic [3:0]  acc_be_q;
  logic [2:0]  acc_cntrl_q;
  logic [4:0]  acc_rdst_q;

  logic        valid_q, misalign_q;
  logic [31:0] pc_q, data_q, alu_q;
  logic [2:0]  cntrl_q;
  logic [4:0]  rdst_q;

  logic        is_wr, is_mem, lane_mis;
  logic        start_acc, bad_acc, pass_alu, ack_done;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld, req_addr;

  assign is_wr  = i_ma_mem_cntrl[MA_WR];
  assign is_mem = i_ma_mem_cntrl[MA_RD] | is_wr;

`ifdef MA_SUBWORD_EN
  assign req_addr = i_ma_alu_rslt;
`else
  assign req_addr = {i_ma_alu_rslt[31:2], 2'b00};
`endif

  ma_lane_align u_lane (
    .st_addr_lo  (i_ma_alu_rslt[1:0]),
    .st_size     (i_ma_mem_cntrl[MA_SIZE_HI:MA_SIZE_LO]),
    .st_data     (i_ma_st_data),
    .st_be       (lane_be),
    .st_wdata    (lane_wdata),
    .misalign    (lane_mis),
    .ld_addr_lo  (acc_addr_q[1:0]),
    .ld_size     (acc_size_q),
    .ld_unsigned (acc_uns_q),
    .rdata       (i_dm_rdata),
    .ld_data     (lane_ld)
  );

  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    bad_acc    = 1'b0;
    pass_alu   = 1'b0;
    ack_done   = 1'b0;
    o_ma_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_ma_valid) begin
          if (!is_mem) begin
            pass_alu = 1'b1;
          end else if (lane_mis) begin
            bad_acc = 1'b1;
          end else begin
            start_acc  = 1'b1;
            o_ma_stall = 1'b1;
            state_d    = StAccess;
          end
        end
      end
      StAccess: begin
        if (i_dm_ack) begin
          ack_done = 1'b1;
          state_d  = StIdle;
        end else begin
          o_ma_stall = 1'b1;
        end
      end
    endcase
    // Upstream may present a valid instruction while reset is held.
    if (!rst) o_ma_stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_we_q    <= 1'b0;
      acc_uns_q   <= 1'b0;
      acc_size_q  <= 2'b00;
      acc_addr_q  <= 32'h0;
      acc_wdata_q <= 32'h0;
      acc_be_q    <= 4'h0;
      acc_pc_q    <= 32'h0;
      acc_alu_q   <= 32'h0;
      acc_cntrl_q <= 3'b000;
      acc_rdst_q  <= 5'd0;
    end else if (start_acc) begin
      acc_we_q    <= is_wr;
      acc_uns_q   <= i_ma_mem_cntrl[MA_UNS];
      acc_size_q  <= i_ma_mem_cntrl[MA_SIZE_HI:MA_SIZE_LO];
      acc_addr_q  <= req_addr;
      acc_wdata_q <= lane_wdata;
      acc_be_q    <= lane_be;
      acc_pc_q    <= i_ma_pc;
      acc_alu_q   <= i_ma_alu_rslt;
      acc_cntrl_q <= i_ma_wb_cntrl;
      acc_rdst_q  <= i_ma_rdst;
    end
  end

  // Pipeline register: a bubble unless a non-memory op passes or an access completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= 32'h0;
      data_q     <= 32'h0;
      alu_q      <= 32'h0;
      cntrl_q    <= 3'b000;
      rdst_q     <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bad_acc;
      if (pass_alu) begin
        valid_q <= 1'b1;
        pc_q    <= i_ma_pc;
        data_q  <= 32'h0;
        alu_q   <= i_ma_alu_rslt;
        cntrl_q <= i_ma_wb_cntrl;
        rdst_q  <= i_ma_rdst;
      end else if (ack_done) begin
        valid_q <= 1'b1;
        pc_q    <= acc_pc_q;
        data_q  <= acc_we_q ? 32'h0 : lane_ld;
        alu_q   <= acc_alu_q;
        cntrl_q <= acc_cntrl_q;
        rdst_q  <= acc_rdst_q;
      end else begin
        valid_q <= 1'b0;
        pc_q    <= 32'h0;
        data_q  <= 32'h0;
        alu_q   <= 32'h0;
        cntrl_q <= 3'b000;
        rdst_q  <= 5'd0;
      end
    end
  end

  assign o_dm_req      = (state_q == StAccess);
  assign o_dm_we       = o_dm_req & acc_we_q;
  assign o_dm_be       = o_dm_req ? acc_be_q : 4'h0;
  assign o_dm_addr     = acc_addr_q;
  assign o_dm_wdata    = acc_wdata_q;
  assign o_ma_misalign = misalign_q;
  assign o_ma_valid    = valid_q;
  assign o_ma_pc       = pc_q;
  assign o_ma_data_o   = data_q;
  assign o_ma_alu_rslt = alu_q;
  assign o_ma_cntrl    = cntrl_q;
  assign o_ma_rdst     = rdst_q;

endmodule

// File: tb/tb_stage_ma.sv
// Self-checking bench for stage_ma: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_stage_ma;

  logic        clk;
  logic        rst;
  logic        i_ma_valid;
  logic [31:0] i_ma_pc, i_ma_alu_rslt, i_ma_st_data;
  logic [4:0]  i_ma_mem_cntrl;
  logic [2:0]  i_ma_wb_cntrl;
  logic [4:0]  i_ma_rdst;
  logic        o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr, o_dm_wdata;
  logic [3:0]  o_dm_be;
  logic        i_dm_ack;
  logic [31:0] i_dm_rdata;
  logic        o_ma_stall, o_ma_misalign, o_ma_valid;
  logic [31:0] o_ma_pc, o_ma_data_o, o_ma_alu_rslt;
  logic [2:0]  o_ma_cntrl;
  logic [4:0]  o_ma_rdst;

  int checks   = 0;
  int failures = 0;

  stage_ma dut (
    .clk           (clk),
    .rst           (rst),
    .i_ma_valid    (i_ma_valid),
    .i_ma_pc       (i_ma_pc),
    .i_ma_alu_rslt (i_ma_alu_rslt),
    .i_ma_st_data  (i_ma_st_data),
    .i_ma_mem_cntrl(i_ma_mem_cntrl),
    .i_ma_wb_cntrl (i_ma_wb_cntrl),
    .i_ma_rdst     (i_ma_rdst),
    .o_dm_req      (o_dm_req),
    .o_dm_we       (o_dm_we),
    .o_dm_addr     (o_dm_addr),
    .o_dm_wdata    (o_dm_wdata),
    .o_dm_be       (o_dm_be),
    .i_dm_ack      (i_dm_ack),
    .i_dm_rdata    (i_dm_rdata),
    .o_ma_stall    (o_ma_stall),
    .o_ma_misalign (o_ma_misalign),
    .o_ma_valid    (o_ma_valid),
    .o_ma_pc       (o_ma_pc),
    .o_ma_data_o   (o_ma_data_o),
    .o_ma_alu_rslt (o_ma_alu_rslt),
    .o_ma_cntrl    (o_ma_cntrl),
    .o_ma_rdst     (o_ma_rdst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic m_is_mem(input logic [4:0] m);
    return m[0] | m[1];
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
`ifdef MA_SUBWORD_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic m_mis(input logic [4:0] m, input logic [31:0] a);
`ifdef MA_SUBWORD_EN
    if (m[3:2] == 2'd0) return 1'b0;
    if (m[3:2] == 2'd1) return a[0];
    return a[1:0] != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [4:0] m, input logic [31:0] a);
`ifdef MA_SUBWORD_EN
    int s;
    s = int'(a[1:0]);
    if (m[3:2] == 2'd0) return 4'(1 << s);
    if (m[3:2] == 2'd1) return 4'(3 << s);
`endif
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [4:0] m, input logic [31:0] st);
`ifdef MA_SUBWORD_EN
    if (m[3:2] == 2'd0) return {24'h0, st[7:0]} * 32'h0101_0101;
    if (m[3:2] == 2'd1) return {16'h0, st[15:0]} * 32'h0001_0001;
`endif
    return st;
  endfunction

  function automatic logic [31:0] m_load(input logic [4:0] m, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(a[1:0]));
`ifdef MA_SUBWORD_EN
    if (m[3:2] == 2'd0) begin
      v = v & 32'hFF;
      if (!m[4] && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (m[3:2] == 2'd1) begin
      v = v & 32'hFFFF;
      if (!m[4] && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
`endif
    return rd;
  endfunction

  // model state: one outstanding access, plus what the MA/WB register must show
  logic        busy;
  logic [4:0]  p_mem;
  logic [31:0] p_alu, p_st, p_pc;
  logic [2:0]  p_wb;
  logic [4:0]  p_rd;
  logic        e_v, e_ld, e_mis;
  logic [31:0] e_pc, e_alu, e_data;
  logic [2:0]  e_c;
  logic [4:0]  e_rd;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req", o_dm_req, 0);
      chk("rst_we", o_dm_we, 0);
      chk("rst_be", o_dm_be, 0);
      chk("rst_stall", o_ma_stall, 0);
      chk("rst_misalign", o_ma_misalign, 0);
      chk("rst_valid", o_ma_valid, 0);
      chk("rst_pc", o_ma_pc, 0);
      chk("rst_data", o_ma_data_o, 0);
      chk("rst_alu", o_ma_alu_rslt, 0);
      chk("rst_cntrl", o_ma_cntrl, 0);
      chk("rst_rdst", o_ma_rdst, 0);
      busy = 0; e_v = 0; e_ld = 0; e_mis = 0; e_c = 0;
      e_pc = 0; e_alu = 0; e_data = 0; e_rd = 0;
    end else begin
      if (busy) begin
        chk("m_req", o_dm_req, 1);
        chk("m_we", o_dm_we, p_mem[1]);
        chk("m_addr", o_dm_addr, m_addr(p_alu));
        chk("m_be", o_dm_be, m_be(p_mem, p_alu));
        chk("m_wdata", o_dm_wdata, m_wdata(p_mem, p_st));
        chk("m_stall_acc", o_ma_stall, !i_dm_ack);
      end else begin
        chk("m_req_idle", o_dm_req, 0);
        chk("m_we_idle", o_dm_we, 0);
        chk("m_be_idle", o_dm_be, 0);
        chk("m_stall_idle", o_ma_stall,
            i_ma_valid && m_is_mem(i_ma_mem_cntrl) && !m_mis(i_ma_mem_cntrl, i_ma_alu_rslt));
      end
      chk("m_valid", o_ma_valid, e_v);
      chk("m_cntrl", o_ma_cntrl, e_c);
      chk("m_misalign", o_ma_misalign, e_mis);
      if (e_v) begin
        chk("m_pc", o_ma_pc, e_pc);
        chk("m_alu", o_ma_alu_rslt, e_alu);
        chk("m_rdst", o_ma_rdst, e_rd);
        if (e_ld) chk("m_ldata", o_ma_data_o, e_data);
      end
      // what the next edge must produce
      e_v = 0; e_c = 0; e_ld = 0; e_mis = 0;
      if (busy) begin
        if (i_dm_ack) begin
          e_v = 1; e_c = p_wb; e_pc = p_pc; e_alu = p_alu; e_rd = p_rd;
          e_ld = !p_mem[1]; e_data = m_load(p_mem, p_alu, i_dm_rdata);
          busy = 0;
        end
      end else if (i_ma_valid) begin
        if (!m_is_mem(i_ma_mem_cntrl)) begin
          e_v = 1; e_c = i_ma_wb_cntrl; e_pc = i_ma_pc; e_alu = i_ma_alu_rslt; e_rd = i_ma_rdst;
        end else if (m_mis(i_ma_mem_cntrl, i_ma_alu_rslt)) begin
          e_mis = 1;
        end else begin
          busy = 1; p_mem = i_ma_mem_cntrl; p_alu = i_ma_alu_rslt; p_st = i_ma_st_data;
          p_pc = i_ma_pc; p_wb = i_ma_wb_cntrl; p_rd = i_ma_rdst;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] m, input logic [31:0] a,
                           input logic [31:0] st, input logic [2:0] wb, input logic [4:0] rd,
                           input logic [31:0] pc);
    i_ma_valid = v; i_ma_mem_cntrl = m; i_ma_alu_rslt = a; i_ma_st_data = st;
    i_ma_wb_cntrl = wb; i_ma_rdst = rd; i_ma_pc = pc;
  endtask

  logic        cap_req, cap_we, cap_valid;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata, cap_addr, cap_data;

  // one memory op acknowledged on its first ACCESS cycle
  task automatic do_mem(input logic [4:0] m, input logic [31:0] a, input logic [31:0] st,
                        input logic [31:0] rd);
    set_instr(1, m, a, st, 3'b101, 5'd7, 32'h400);
    i_dm_ack = 0; i_dm_rdata = rd;
    step;
    i_dm_ack = 1;
    @(negedge clk);
    cap_req = o_dm_req; cap_we = o_dm_we; cap_be = o_dm_be;
    cap_wdata = o_dm_wdata; cap_addr = o_dm_addr;
    step;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    i_dm_ack = 0;
    cap_data = o_ma_data_o; cap_valid = o_ma_valid;
  endtask

  int  stall_cnt, bub_bad, req_cnt, mis_cnt;
  logic held;

  initial begin
    rst = 0; i_dm_ack = 0; i_dm_rdata = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    step;

    // ALU op passes in one cycle
    set_instr(1, 5'b00000, 32'h1234, 0, 3'b100, 5'd9, 32'h10);
    @(negedge clk);
    chk("alu_req", o_dm_req, 0);
    chk("alu_stall", o_ma_stall, 0);
    step;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    chk("alu_valid", o_ma_valid, 1);
    chk("alu_rslt", o_ma_alu_rslt, 32'h1234);
    chk("alu_cntrl", o_ma_cntrl, 3'b100);

    // word load, ack three cycles into ACCESS
    set_instr(1, 5'b01001, 32'h100, 0, 3'b101, 5'd4, 32'h20);
    i_dm_rdata = 32'hDEAD_BEEF;
    stall_cnt = 0; bub_bad = 0;
    for (int k = 0; k < 5; k++) begin
      i_dm_ack = (k == 4);
      @(negedge clk);
      if (o_ma_stall) stall_cnt++;
      if (k > 0 && o_ma_valid) bub_bad++;
      step;
    end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    i_dm_ack = 0;
    chk("lw_stall_cycles", stall_cnt, 4);
    chk("lw_bubbles", bub_bad, 0);
    chk("lw_valid", o_ma_valid, 1);
    chk("lw_data", o_ma_data_o, 32'hDEAD_BEEF);

    // byte loads at 0x103, signed then unsigned
    do_mem(5'b00001, 32'h103, 0, 32'h8000_0000);
    chk("lb_valid", cap_valid, 1);
`ifdef MA_SUBWORD_EN
    chk("lb_signed", cap_data, 32'hFFFF_FF80);
`else
    chk("lb_signed", cap_data, 32'h8000_0000);
`endif
    do_mem(5'b10001, 32'h103, 0, 32'h8000_0000);
`ifdef MA_SUBWORD_EN
    chk("lbu_unsigned", cap_data, 32'h0000_0080);
`else
    chk("lbu_unsigned", cap_data, 32'h8000_0000);
`endif

    // half store at 0x202
    do_mem(5'b00110, 32'h202, 32'h1234_ABCD, 0);
    chk("sh_req", cap_req, 1);
    chk("sh_we", cap_we, 1);
`ifdef MA_SUBWORD_EN
    chk("sh_be", cap_be, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_addr", cap_addr, 32'h202);
`else
    chk("sh_be", cap_be, 4'hF);
    chk("sh_wdata", cap_wdata, 32'h1234_ABCD);
    chk("sh_addr", cap_addr, 32'h200);
`endif

    // read and write both set acts as a write
    do_mem(5'b01011, 32'h40, 32'h5555_AAAA, 32'hFFFF_FFFF);
    chk("rw_we", cap_we, 1);

    // word load at 0x101
`ifdef MA_SUBWORD_EN
    set_instr(1, 5'b01001, 32'h101, 0, 3'b101, 5'd2, 32'h30);
    req_cnt = 0; mis_cnt = 0;
    @(negedge clk);
    req_cnt += int'(o_dm_req); mis_cnt += int'(o_ma_misalign);
    step;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    req_cnt += int'(o_dm_req); mis_cnt += int'(o_ma_misalign);
    chk("mis_cntrl", o_ma_cntrl, 0);
    chk("mis_valid", o_ma_valid, 0);
    step;
    @(negedge clk);
    req_cnt += int'(o_dm_req); mis_cnt += int'(o_ma_misalign);
    chk("mis_pulses", mis_cnt, 1);
    chk("mis_reqs", req_cnt, 0);
    step;
`else
    do_mem(5'b01001, 32'h101, 0, 32'h1357_9BDF);
    chk("mis_req", cap_req, 1);
    chk("mis_addr", cap_addr, 32'h100);
    chk("mis_data", cap_data, 32'h1357_9BDF);
    chk("mis_flag", o_ma_misalign, 0);
`endif

    // reset pulled mid-ACCESS, then a stray ack
    set_instr(1, 5'b01001, 32'h300, 0, 3'b101, 5'd3, 32'h44);
    i_dm_ack = 0;
    step;
    chk("rst_acc_req_before", o_dm_req, 1);
    #2 rst = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_acc_req", o_dm_req, 0);
    chk("rst_acc_we", o_dm_we, 0);
    chk("rst_acc_be", o_dm_be, 0);
    chk("rst_acc_stall", o_ma_stall, 0);
    @(posedge clk);
    #1 rst = 1;
    i_dm_ack = 1; i_dm_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("stray_ack_req", o_dm_req, 0);
    step;
    chk("stray_ack_valid", o_ma_valid, 0);
    i_dm_ack = 0;
    step;

    // randomized traffic; upstream holds its instruction while stalled
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      held = o_ma_stall;
      step;
      if (!held) begin
        i_ma_valid     = ($urandom_range(0, 9) != 0);
        i_ma_mem_cntrl = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                          2'($urandom_range(0, 3))};
        i_ma_alu_rslt  = $urandom;
        i_ma_st_data   = $urandom;
        i_ma_pc        = $urandom;
        i_ma_wb_cntrl  = 3'($urandom);
        i_ma_rdst      = 5'($urandom);
      end
      i_dm_ack   = ($urandom_range(0, 2) == 0);
      i_dm_rdata = $urandom;
    end

    set_instr(0, 0, 0, 0, 0, 0, 0);
    i_dm_ack = 1;
    repeat (4) step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
